myip_v1_0: RTL and testbench

- AXI4-Stream coprocessor: a slave port accepts a fixed-length packet of 32-bit words and accumulates their sum; a master port then emits the result.
- Sits between a DMA MM2S stream and an S2MM stream as a minimal accelerator template.
- Processing is strictly sequential, one packet at a time: receive, then transmit.

---
 rtl/myip_v1_0.sv | 94 +++++++++
 tb/tb_myip_v1_0.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/myip_v1_0.sv
// AXI4-Stream summing coprocessor: accumulates a fixed-length packet of
// 32-bit words on the slave port, then emits the sum on the master port.
module myip_v1_0 #(
  parameter int NUMBER_OF_INPUT_WORDS  = 2,
  parameter int NUMBER_OF_OUTPUT_WORDS = 1
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);

  localparam int RD_W = (NUMBER_OF_INPUT_WORDS  > 1) ? $clog2(NUMBER_OF_INPUT_WORDS)  : 1;
  localparam int WR_W = (NUMBER_OF_OUTPUT_WORDS > 1) ? $clog2(NUMBER_OF_OUTPUT_WORDS) : 1;
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(NUMBER_OF_INPUT_WORDS - 1);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(NUMBER_OF_OUTPUT_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_INPUTS   = 2'd1,
    WRITE_OUTPUTS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       sum_q, sum_d;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;

  // Packet length is fixed by parameter, so the incoming last flag is unused.
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d  = state_q;
    sum_d    = sum_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    unique case (state_q)
      IDLE: begin
        // Entry edge only arms the datapath; the word present now is not taken.
        if (S_AXIS_TVALID) begin
          state_d  = READ_INPUTS;
          sum_d    = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      READ_INPUTS: begin
        if (S_AXIS_TVALID) begin
          sum_d    = sum_q + S_AXIS_TDATA;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == RD_LAST) state_d = WRITE_OUTPUTS;
        end
      end
      WRITE_OUTPUTS: begin
        if (M_AXIS_TREADY) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == WR_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge, independent of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Outputs decode registered state only: no input-to-output combinational path.
  assign S_AXIS_TREADY = (state_q == READ_INPUTS);
  assign M_AXIS_TVALID = (state_q == WRITE_OUTPUTS);
  assign M_AXIS_TDATA  = sum_q;
  assign M_AXIS_TLAST  = (state_q == WRITE_OUTPUTS) && (wr_cnt_q == WR_LAST);

endmodule

// File: tb/tb_myip_v1_0.sv
// Directed bench for myip_v1_0: two-word packets, stalls, backpressure,
// overflow, mid-packet reset and back-to-back packets.
module tb_myip_v1_0;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;

  int vectors     = 0;
  int miscompares = 0;

  myip_v1_0 #(.NUMBER_OF_INPUT_WORDS(2), .NUMBER_OF_OUTPUT_WORDS(1)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Present a word and take one edge; caller checks the result.
  task automatic drive_word(input logic [31:0] data);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = data;
    step();
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0;
    S_AXIS_TLAST = 1'b0; M_AXIS_TREADY = 1'b0;
    step(); step();
    vectors++; if (S_AXIS_TREADY !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready got %b want 0", S_AXIS_TREADY); end
    vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid got %b want 0", M_AXIS_TVALID); end
    vectors++; if (M_AXIS_TLAST  !== 1'b0) begin miscompares++; $display("FAIL reset_m_tlast got %b want 0", M_AXIS_TLAST); end
    vectors++; if (M_AXIS_TDATA  !== 32'h0) begin miscompares++; $display("FAIL reset_m_tdata got %h want 0", M_AXIS_TDATA); end
    ARESETN = 1'b1;
  endtask

  task automatic test_basic();
    M_AXIS_TREADY = 1'b1;
    drive_word(32'h0000FE40); // IDLE exit edge, not consumed
    vectors++; if (S_AXIS_TREADY !== 1'b1) begin miscompares++; $display("FAIL basic_tready_1 got %b want 1", S_AXIS_TREADY); end
    drive_word(32'h0000FE40);
    vectors++; if (S_AXIS_TREADY !== 1'b1) begin miscompares++; $display("FAIL basic_tready_2 got %b want 1", S_AXIS_TREADY); end
    vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL basic_tvalid_early got %b want 0", M_AXIS_TVALID); end
    drive_word(32'h00046000);
    S_AXIS_TVALID = 1'b0;
    vectors++; if (S_AXIS_TREADY !== 1'b0) begin miscompares++; $display("FAIL basic_tready_3 got %b want 0", S_AXIS_TREADY); end
    vectors++; if (M_AXIS_TVALID !== 1'b1) begin miscompares++; $display("FAIL basic_tvalid got %b want 1", M_AXIS_TVALID); end
    vectors++; if (M_AXIS_TDATA !== 32'h00055E40) begin miscompares++; $display("FAIL basic_tdata got %h want 00055e40", M_AXIS_TDATA); end
    vectors++; if (M_AXIS_TLAST !== 1'b1) begin miscompares++; $display("FAIL basic_tlast got %b want 1", M_AXIS_TLAST); end
    step();
    vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL basic_idle_tvalid got %b want 0", M_AXIS_TVALID); end
    vectors++; if (M_AXIS_TLAST !== 1'b0) begin miscompares++; $display("FAIL basic_idle_tlast got %b want 0", M_AXIS_TLAST); end
    vectors++; if (S_AXIS_TREADY !== 1'b0) begin miscompares++; $display("FAIL basic_idle_tready got %b want 0", S_AXIS_TREADY); end
  endtask

  task automatic test_slave_stall();
    M_AXIS_TREADY = 1'b1;
    drive_word(32'd20);
    drive_word(32'd20);
    for (int i = 0; i < 3; i++) begin
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TDATA  = 32'hBAD0_0000 + i;
      step();
      vectors++; if (S_AXIS_TREADY !== 1'b1) begin miscompares++; $display("FAIL stall_tready[%0d] got %b want 1", i, S_AXIS_TREADY); end
      vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL stall_tvalid[%0d] got %b want 0", i, M_AXIS_TVALID); end
    end
    drive_word(32'h00C80264);
    S_AXIS_TVALID = 1'b0;
    vectors++; if (M_AXIS_TDATA !== 32'h00C80278) begin miscompares++; $display("FAIL stall_tdata got %h want 00c80278", M_AXIS_TDATA); end
    vectors++; if (M_AXIS_TLAST !== 1'b1) begin miscompares++; $display("FAIL stall_tlast got %b want 1", M_AXIS_TLAST); end
    step();
  endtask

  task automatic test_backpressure();
    M_AXIS_TREADY = 1'b0;
    drive_word(32'h11111111);
    drive_word(32'h11111111);
    drive_word(32'h22222222);
    S_AXIS_TVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (M_AXIS_TVALID !== 1'b1) begin miscompares++; $display("FAIL bp_tvalid[%0d] got %b want 1", i, M_AXIS_TVALID); end
      vectors++; if (M_AXIS_TDATA !== 32'h33333333) begin miscompares++; $display("FAIL bp_tdata[%0d] got %h want 33333333", i, M_AXIS_TDATA); end
      step();
    end
    vectors++; if (M_AXIS_TVALID !== 1'b1) begin miscompares++; $display("FAIL bp_hold_end got %b want 1", M_AXIS_TVALID); end
    M_AXIS_TREADY = 1'b1;
    step();
    vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL bp_done got %b want 0", M_AXIS_TVALID); end
  endtask

  task automatic test_overflow();
    M_AXIS_TREADY = 1'b1;
    drive_word(32'hFFFFFFFF);
    drive_word(32'hFFFFFFFF);
    drive_word(32'h00000002);
    S_AXIS_TVALID = 1'b0;
    vectors++; if (M_AXIS_TDATA !== 32'h00000001) begin miscompares++; $display("FAIL overflow_tdata got %h want 00000001", M_AXIS_TDATA); end
    step();
  endtask

  task automatic test_reset_mid_packet();
    M_AXIS_TREADY = 1'b1;
    drive_word(32'h00000100);
    drive_word(32'h00000100);
    S_AXIS_TVALID = 1'b0;
    ARESETN = 1'b0;
    #1;
    vectors++; if (S_AXIS_TREADY !== 1'b0) begin miscompares++; $display("FAIL midrst_tready got %b want 0", S_AXIS_TREADY); end
    vectors++; if (M_AXIS_TDATA !== 32'h0) begin miscompares++; $display("FAIL midrst_tdata got %h want 0", M_AXIS_TDATA); end
    step(); step();
    ARESETN = 1'b1;
    drive_word(32'd5);
    drive_word(32'd5);
    drive_word(32'd7);
    S_AXIS_TVALID = 1'b0;
    vectors++; if (M_AXIS_TVALID !== 1'b1) begin miscompares++; $display("FAIL midrst_tvalid got %b want 1", M_AXIS_TVALID); end
    vectors++; if (M_AXIS_TDATA !== 32'd12) begin miscompares++; $display("FAIL midrst_tdata_sum got %h want 0000000c", M_AXIS_TDATA); end
    step();
  endtask

  task automatic test_back_to_back();
    M_AXIS_TREADY = 1'b1;
    drive_word(32'd1);
    drive_word(32'd1);
    drive_word(32'd2);
    vectors++; if (M_AXIS_TDATA !== 32'd3) begin miscompares++; $display("FAIL b2b_first got %h want 00000003", M_AXIS_TDATA); end
    drive_word(32'hDEAD0000); // output beat; slave word must not be taken
    vectors++; if (S_AXIS_TREADY !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_tready got %b want 0", S_AXIS_TREADY); end
    vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_tvalid got %b want 0", M_AXIS_TVALID); end
    drive_word(32'hDEAD0001); // IDLE exit, still not consumed
    vectors++; if (S_AXIS_TREADY !== 1'b1) begin miscompares++; $display("FAIL b2b_restart got %b want 1", S_AXIS_TREADY); end
    drive_word(32'd4);
    drive_word(32'd5);
    S_AXIS_TVALID = 1'b0;
    vectors++; if (M_AXIS_TDATA !== 32'd9) begin miscompares++; $display("FAIL b2b_second got %h want 00000009", M_AXIS_TDATA); end
    vectors++; if (M_AXIS_TLAST !== 1'b1) begin miscompares++; $display("FAIL b2b_tlast got %b want 1", M_AXIS_TLAST); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slave_stall();
    test_backpressure();
    test_overflow();
    test_reset_mid_packet();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
